card_hand: RTL and testbench

Per-player card-hand tracker for the black-and-white card game. It holds and updates the 10-bit remaining-card bitmap `p_card`, which the `blackandwhite` counter consumes to report remaining black and white cards. It accepts one card play per round through a valid/ready handshake, retires the played card, and announces the card's colour to the round-comparison logic.

---
 rtl/card_hand.sv | 100 ++++++++++
 tb/tb_card_hand.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/card_hand.sv
// card_hand: per-player hand of ten cards (five black, five white).
// Accepts one play per round, retires the played card and announces its colour.
module card_hand (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       play_valid,
  input  logic [3:0] play_value,
  output logic       play_ready,
  output logic [9:0] p_card,
  output logic       played_valid,
  output logic       played_color,
  output logic [3:0] played_value,
  output logic       illegal,
  output logic [3:0] round,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, PLAY, ANNOUNCE, OVER} state_t;

  state_t     state, state_next;
  logic [9:0] p_card_next;
  logic [9:0] play_mask;
  logic [3:0] round_next;
  logic [3:0] bit_idx;
  logic [3:0] played_value_next;
  logic       played_color_next;
  logic       illegal_next;
  logic       legal;

  // Black value 2k sits at bit 5+k, white value 2k+1 at bit k.
  always_comb begin
    bit_idx   = (play_value[0] ? 4'd0 : 4'd5) + {1'b0, play_value[3:1]};
    play_mask = 10'b1 << bit_idx;
    legal     = (play_value <= 4'd9) && ((p_card & play_mask) != 10'b0);
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
    state_next        = state;
    p_card_next       = p_card;
    round_next        = round;
    played_value_next = played_value;
    played_color_next = played_color;
    illegal_next      = 1'b0;

    if (new_game) begin
      state_next  = PLAY;
      p_card_next = 10'h3FF;
      round_next  = 4'd0;
    end else begin
      unique case (state)
        IDLE: ;
        PLAY: begin
          if (play_valid) begin
            if (legal) begin
              p_card_next       = p_card & ~play_mask;
              played_value_next = play_value;
              played_color_next = ~play_value[0];
              round_next        = (round == 4'd10) ? 4'd10 : round + 4'd1;
              state_next        = ANNOUNCE;
            end else begin
              illegal_next = 1'b1;
            end
          end
        end
        ANNOUNCE: state_next = (p_card == 10'b0) ? OVER : PLAY;
        OVER: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    if (rst) begin
      state        <= IDLE;
      p_card       <= 10'b0;
      round        <= 4'd0;
      played_value <= 4'd0;
      played_color <= 1'b0;
      illegal      <= 1'b0;
      play_ready   <= 1'b0;
      played_valid <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_next;
      p_card       <= p_card_next;
      round        <= round_next;
      played_value <= played_value_next;
      played_color <= played_color_next;
      illegal      <= illegal_next;
      play_ready   <= (state_next == PLAY);
      played_valid <= (state_next == ANNOUNCE);
      game_over    <= (state_next == OVER);
    end
  end

endmodule

// File: tb/tb_card_hand.sv
// Self-checking bench for card_hand: directed scenarios plus randomized games
// compared cycle by cycle against a value-indexed hand model.
module tb_card_hand;

  logic       clk = 1'b0;
  logic       rst, new_game, play_valid;
  logic [3:0] play_value;
  logic       play_ready, played_valid, played_color, illegal, game_over;
  logic [9:0] p_card;
  logic [3:0] played_value, round;

  int checks = 0;
  int errors = 0;

  card_hand dut (
    .clk(clk), .rst(rst), .new_game(new_game), .play_valid(play_valid),
    .play_value(play_value), .play_ready(play_ready), .p_card(p_card),
    .played_valid(played_valid), .played_color(played_color),
    .played_value(played_value), .illegal(illegal), .round(round),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model: hand[v] = 1 while card of value v is held.
  bit         hand [10];
  int         m_round;
  bit         m_started, m_announcing, m_over, m_illegal;
  logic [3:0] m_value;
  logic       m_color;

  function automatic logic [9:0] model_pcard();
    logic [9:0] r = 10'b0;
    for (int v = 0; v < 10; v++)
      if (hand[v]) r[(v % 2 == 1) ? v / 2 : 5 + v / 2] = 1'b1;
    return r;
  endfunction

  function automatic bit hand_empty();
    for (int v = 0; v < 10; v++) if (hand[v]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [22:0] exp_vec();
    logic ready = m_started && !m_announcing && !m_over;
    return {ready, model_pcard(), m_announcing, m_color, m_value, m_illegal,
            4'(m_round), m_over};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {play_ready, p_card, played_valid, played_color, played_value,
            illegal, round, game_over};
  endfunction

  task automatic model_edge(input logic r, input logic ng, input logic pv,
                            input logic [3:0] v);
    bit playing = m_started && !m_announcing && !m_over;
    m_illegal = 1'b0;
    if (r) begin
      foreach (hand[i]) hand[i] = 1'b0;
      m_round = 0; m_started = 0; m_announcing = 0; m_over = 0;
      m_value = 4'd0; m_color = 1'b0;
    end else if (ng) begin
      foreach (hand[i]) hand[i] = 1'b1;
      m_round = 0; m_started = 1; m_announcing = 0; m_over = 0;
    end else if (m_announcing) begin
      m_announcing = 0;
      m_over = hand_empty();
    end else if (playing && pv) begin
      if (v <= 9 && hand[v]) begin
        hand[v] = 1'b0;
        m_round = (m_round < 10) ? m_round + 1 : 10;
        m_value = v;
        m_color = ~v[0];
        m_announcing = 1;
      end else begin
        m_illegal = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input logic r, input logic ng, input logic pv,
                      input logic [3:0] v);
    rst = r; new_game = ng; play_valid = pv; play_value = v;
    @(posedge clk);
    model_edge(r, ng, pv, v);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 1, 4'd3);
    checks++;
    if (dut_vec() !== 23'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", dut_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 4'(i));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_ignores_play got=%h want=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_new_game();
    step(0, 1, 0, 0);
    checks++;
    if (p_card !== 10'h3FF || round !== 4'd0 || play_ready !== 1'b1) begin
      errors++;
      $display("FAIL new_game got p_card=%b round=%0d ready=%b want 1111111111/0/1",
               p_card, round, play_ready);
    end
  endtask

  task automatic test_legal_play();
    step(0, 0, 1, 4'd4);
    checks++;
    if (dut_vec() !== {1'b0, 10'b1101111111, 1'b1, 1'b1, 4'd4, 1'b0, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL play_4 got=%h want p_card=1101111111 valid=1 color=1 value=4 round=1", dut_vec());
    end
    step(0, 0, 0, 0);
    checks++;
    if (play_ready !== 1'b1 || played_valid !== 1'b0) begin
      errors++;
      $display("FAIL announce_end got ready=%b valid=%b want 1/0", play_ready, played_valid);
    end
    step(0, 0, 1, 4'd7);
    checks++;
    if (p_card !== 10'b1101110111 || played_color !== 1'b0 || played_value !== 4'd7) begin
      errors++;
      $display("FAIL play_7 got p_card=%b color=%b value=%0d want 1101110111/0/7",
               p_card, played_color, played_value);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_illegal();
    logic [3:0] vals [2] = '{4'd4, 4'd12};
    foreach (vals[i]) begin
      step(0, 0, 1, vals[i]);
      checks++;
      if (illegal !== 1'b1 || played_valid !== 1'b0 || p_card !== 10'b1101110111 ||
          round !== 4'd2 || play_ready !== 1'b1) begin
        errors++;
        $display("FAIL illegal_%0d got ill=%b valid=%b p_card=%b round=%0d ready=%b",
                 vals[i], illegal, played_valid, p_card, round, play_ready);
      end
      step(0, 0, 0, 0);
      checks++;
      if (illegal !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse_width got=%b want=0", illegal);
      end
    end
  endtask

  task automatic test_full_game();
    step(0, 1, 0, 0);
    for (int v = 0; v < 10; v++) begin
      step(0, 0, 1, 4'(v));
      // A play offered during ANNOUNCE must be neither accepted nor flagged.
      step(0, 0, 1, 4'((v + 1) % 10));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_game_v%0d got=%h want=%h", v, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (p_card !== 10'b0 || round !== 4'd10 || game_over !== 1'b1 || play_ready !== 1'b0) begin
      errors++;
      $display("FAIL game_over got p_card=%b round=%0d over=%b ready=%b want 0/10/1/0",
               p_card, round, game_over, play_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 4'(i));
      checks++;
      if (dut_vec() !== exp_vec() || illegal !== 1'b0) begin
        errors++;
        $display("FAIL over_ignores_play got=%h want=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_new_game_override();
    step(0, 1, 0, 0);
    for (int v = 1; v <= 3; v++) begin
      step(0, 0, 1, 4'(v));
      step(0, 0, 0, 0);
    end
    step(0, 1, 1, 4'd8);
    checks++;
    if (p_card !== 10'h3FF || round !== 4'd0 || played_valid !== 1'b0 ||
        illegal !== 1'b0 || play_ready !== 1'b1) begin
      errors++;
      $display("FAIL new_game_override got p_card=%b round=%0d valid=%b ill=%b ready=%b",
               p_card, round, played_valid, illegal, play_ready);
    end
  endtask

  task automatic test_reset_in_announce();
    step(0, 0, 1, 4'd5);
    step(1, 0, 0, 0);
    checks++;
    if (dut_vec() !== 23'b0) begin
      errors++;
      $display("FAIL reset_announce got=%h want=0", dut_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 4'(i + 6));
      checks++;
      if (p_card !== 10'b0 || round !== 4'd0 || play_ready !== 1'b0 || played_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_play got p_card=%b round=%0d ready=%b valid=%b",
                 p_card, round, play_ready, played_valid);
      end
    end
  endtask

  task automatic test_random();
    step(0, 1, 0, 0);
    for (int c = 0; c < 600; c++) begin
      logic ng  = ($urandom_range(0, 39) == 0) || (m_over && $urandom_range(0, 2) == 0);
      logic pv  = ($urandom_range(0, 3) != 0);
      logic [3:0] v = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      step(0, ng, pv, v);
      checks++;
      if (dut_vec() !== exp_vec() || $countones(p_card) + int'(round) != 10) begin
        errors++;
        $display("FAIL random_c%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; new_game = 1'b0; play_valid = 1'b0; play_value = 4'd0;
    test_reset();
    test_new_game();
    test_legal_play();
    test_illegal();
    test_full_game();
    test_new_game_override();
    test_reset_in_announce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
